// File: rtl/packet_transmitter_pkg.sv
// Shared definitions for the packet transmitter: FSM state encodings,
// the default bit-clock divider and the byte parity helper.
package packet_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Transmitter clock delay: clk cycles per serial bit.
  localparam int unsigned TX_CLK_DELAY = 16;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_byte_shifter.sv
// Shifts one byte (plus optional even parity) onto a serial line with a
// mid-bit rising clock; start_i loads a byte, byte_done_o flags its last cycle.
module serial_byte_shifter
  import packet_transmitter_pkg::*;
#(
  parameter int unsigned CLK_DIV   = TX_CLK_DELAY,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       byte_done_o,
  output logic       tx_o,
  output logic       clock_o,
  output logic       data_o
);

  localparam int unsigned     NBITS    = 8 + (PARITY_EN ? 1 : 0);
  localparam int unsigned     PH_W     = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF  = PH_W'(CLK_DIV / 2);
  localparam logic [3:0]      BIT_LAST = 4'(NBITS - 1);

  logic            active_q, active_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_q, clock_q, data_q;

  function automatic logic pick_bit(input logic [7:0] b, input logic [3:0] idx);
    if (idx[3]) return even_parity(b);
    return MSB_FIRST ? b[3'd7 - idx[2:0]] : b[idx[2:0]];
  endfunction

  assign byte_done_o = active_q && (phase_q == PH_LAST) && (bit_q == BIT_LAST);

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
    active_d = active_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    if (start_i) begin
      active_d = 1'b1;
      phase_d  = '0;
      bit_d    = '0;
      byte_d   = byte_i;
    end else if (active_q) begin
      if (phase_q != PH_LAST) begin
        phase_d = phase_q + 1'b1;
      end else begin
        phase_d = '0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          bit_d    = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
    end
  end

  // Serial outputs are flopped from next-state values so pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
      active_q <= 1'b0;
      phase_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b0;
      clock_q  <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= active_d;
      clock_q  <= active_d && (phase_d >= PH_HALF);
      data_q   <= active_d && pick_bit(byte_d, bit_d);
    end
  end

  assign tx_o    = tx_q;
  assign clock_o = clock_q;
  assign data_o  = data_q;

endmodule

// File: rtl/packet_transmitter.sv
// Multi-byte serial transmitter: latches a word on send, then streams its
// bytes (byte 0 first) through the byte shifter with optional idle gaps.
module packet_transmitter
  import packet_transmitter_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned CLK_DIV    = TX_CLK_DELAY,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_EN  = 1'b0,
  parameter int unsigned GAP_BITS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  logic [8*WORD_BYTES-1:0] data,
  output logic                    busy,
  output logic                    done,
  output logic                    transmission,
  output logic                    clock,
  output logic                    out_data
);

  localparam int unsigned      IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned      GAP_CYC  = GAP_BITS * CLK_DIV;
  localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic                    busy_q, done_q;
  logic                    start;
  logic [7:0]              start_byte;
  logic                    byte_done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    word_d  = word_q;
    start   = 1'b0;
    unique case (state_q)
      // DONE accepts a request exactly like IDLE so words can run back to back.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (send) begin
          word_d  = data;
          idx_d   = '0;
          state_d = ST_SHIFT;
          start   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (byte_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else if (GAP_BITS == 0) begin
            idx_d = idx_q + 1'b1;
            start = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = ST_SHIFT;
          start   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_byte = word_d[8*idx_d +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // NOTE: the word buffer is pure datapath, only read once send has loaded it, so it carries no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  serial_byte_shifter #(
    .CLK_DIV  (CLK_DIV),
    .MSB_FIRST(MSB_FIRST),
    .PARITY_EN(PARITY_EN)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .byte_i     (start_byte),
    .byte_done_o(byte_done),
    .tx_o       (transmission),
    .clock_o    (clock),
    .data_o     (out_data)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
